// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source end of a 4-phase req/ack clock-domain-crossing handshake.
// Holds tx_data stable for the whole transfer and synchronizes rx_ack into clk.
module cdc_hs_tx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_req,
   output logic [DATA_W-1:0] tx_data,
   input  logic              rx_ack,
   output logic              done,
   output logic              busy,
   output logic              err,
   input  logic              err_clr,
   output logic [15:0]       xfer_cnt
);

   typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_s;
   logic                   tx_req_q, tx_req_d;
   logic [DATA_W-1:0]      tx_data_q, tx_data_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [15:0]            xfer_cnt_q, xfer_cnt_d;
   logic                   to_hit;

   assign ack_s    = ack_sync_q[SYNC_STAGES-1];
   assign in_ready = (state_q == StIdle) && !ack_s;
   assign busy     = (state_q != StIdle);
   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign done     = done_q;
   assign err      = err_q;
   assign xfer_cnt = xfer_cnt_q;

   always_comb begin
      state_d    = state_q;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
      xfer_cnt_d = xfer_cnt_q;
      case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               tx_data_d = in_data;
               tx_req_d  = 1'b1;
               state_d   = StReq;
            end
         end
         StReq: begin
            if (ack_s) begin
               tx_req_d = 1'b0;
               state_d  = StDrop;
            end
         end
         StDrop: begin
            if (!ack_s) begin
               done_d     = 1'b1;
               xfer_cnt_d = xfer_cnt_q + 16'd1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear has priority so software can always acknowledge an error.
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end else if (to_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         ack_sync_q <= '0;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], rx_ack};
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   if (TIMEOUT > 0) begin : g_timeout
      localparam int unsigned CntW = $clog2(TIMEOUT + 1);
      localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

      logic [CntW-1:0] cnt_q, cnt_d;

      // Only a wait phase that fails to advance ages; the FSM never aborts.
      assign to_hit = (state_q != StIdle) && (state_d == state_q) && (cnt_q == CntMax);

      always_comb begin
         cnt_d = cnt_q;
         if ((state_d != state_q) || (state_q == StIdle)) begin
            cnt_d = '0;
         end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end else begin : g_no_timeout
      assign to_hit = 1'b0;
   end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: two instances (2-stage sync with timeout, 3-stage without)
// checked every cycle against a transaction-level model of the handshake rules.
module tb_cdc_hs_tx;

   localparam int S0 = 2, S1 = 3, TO0 = 16, TO1 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, err_clr;
   logic [7:0] in_data;
   logic       in_ready[2], tx_req[2], done[2], busy[2], err[2], rx_ack[2];
   logic [7:0] tx_data[2];
   logic [15:0] xfer_cnt[2];

   cdc_hs_tx #(.DATA_W(8), .SYNC_STAGES(S0), .TIMEOUT(TO0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
      .tx_req(tx_req[0]), .tx_data(tx_data[0]), .rx_ack(rx_ack[0]), .done(done[0]),
      .busy(busy[0]), .err(err[0]), .err_clr(err_clr), .xfer_cnt(xfer_cnt[0])
   );

   cdc_hs_tx #(.DATA_W(8), .SYNC_STAGES(S1), .TIMEOUT(TO1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
      .tx_req(tx_req[1]), .tx_data(tx_data[1]), .rx_ack(rx_ack[1]), .done(done[1]),
      .busy(busy[1]), .err(err[1]), .err_clr(err_clr), .xfer_cnt(xfer_cnt[1])
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic string tag(input string s, input int i);
      return $sformatf("%s[%0d]", s, i);
   endfunction

   // Reference model: phase 0 = no transfer, 1 = request raised, 2 = waiting for ack release.
   int          sync_n[2];
   int          tmo[2];
   int          m_phase[2];
   logic [7:0]  m_data[2];
   logic        m_done[2], m_err[2], m_acc[2];
   logic [15:0] m_cnt[2];
   int          m_wait[2];
   logic [3:0]  m_hist[2];

   // Destination side stimulus: mode 0 follows tx_req after a random delay, 1 = manual.
   int   mode[2], dcnt[2];
   int   dmin = 0, dmax = 4;
   int   tick_n = 0;
   int   rise_edge[2], n_done_dut[2];
   logic last_ack[2], prev_req[2];

   function automatic logic m_acks(input int i);
      return m_hist[i][sync_n[i]-1];
   endfunction

   task automatic model_reset(input int i);
      m_phase[i] = 0;
      m_data[i]  = '0;
      m_done[i]  = 1'b0;
      m_err[i]   = 1'b0;
      m_acc[i]   = 1'b0;
      m_cnt[i]   = '0;
      m_wait[i]  = 0;
      m_hist[i]  = '0;
   endtask

   task automatic model_step(input int i);
      int   ph0;
      logic a, adv, hit;
      if (rst) begin
         model_reset(i);
         return;
      end
      a   = m_acks(i);
      ph0 = m_phase[i];
      adv = 1'b0;
      hit = 1'b0;
      m_done[i] = 1'b0;
      m_acc[i]  = 1'b0;
      if (ph0 == 0 && in_valid && !a) begin
         m_data[i] = in_data; m_phase[i] = 1; adv = 1'b1; m_acc[i] = 1'b1;
      end else if (ph0 == 1 && a) begin
         m_phase[i] = 2; adv = 1'b1;
      end else if (ph0 == 2 && !a) begin
         m_phase[i] = 0; adv = 1'b1; m_done[i] = 1'b1; m_cnt[i] = m_cnt[i] + 16'd1;
      end
      if (ph0 == 0 || adv) begin
         m_wait[i] = 0;
      end else begin
         if (tmo[i] > 0 && m_wait[i] >= tmo[i] - 1) hit = 1'b1;
         m_wait[i]++;
      end
      if (err_clr) m_err[i] = 1'b0;
      else if (hit) m_err[i] = 1'b1;
      m_hist[i] = {m_hist[i][2:0], rx_ack[i]};
   endtask

   task automatic check_all(input int i);
      check(tag("in_ready", i), in_ready[i], m_phase[i] == 0 && !m_acks(i));
      check(tag("tx_req", i), tx_req[i], m_phase[i] == 1);
      check(tag("tx_data", i), tx_data[i], m_data[i]);
      check(tag("busy", i), busy[i], m_phase[i] != 0);
      check(tag("done", i), done[i], m_done[i]);
      check(tag("err", i), err[i], m_err[i]);
      check(tag("xfer_cnt", i), xfer_cnt[i], m_cnt[i]);
      if (!rst && prev_req[i] && !tx_req[i] && rise_edge[i] >= 0) begin
         check(tag("ack_to_req_fall", i), tick_n - rise_edge[i], sync_n[i]);
         rise_edge[i] = -1;
      end
   endtask

   task automatic drive_ack(input int i);
      if (mode[i] != 0 || rst) return;
      if (tx_req[i] !== rx_ack[i]) begin
         if (dcnt[i] <= 0) begin
            rx_ack[i] = tx_req[i];
            dcnt[i]   = int'($urandom_range(dmax, dmin));
         end else begin
            dcnt[i]--;
         end
      end
   endtask

   // Inputs seen at the last posedge are still applied here, so the model steps first.
   task automatic tick();
      @(negedge clk);
      tick_n++;
      for (int i = 0; i < 2; i++) begin
         if (rx_ack[i] && !last_ack[i]) rise_edge[i] = tick_n;
         last_ack[i] = rx_ack[i];
         model_step(i);
         if (rst) rise_edge[i] = -1;
         check_all(i);
         prev_req[i] = tx_req[i];
         if (done[i]) n_done_dut[i]++;
         drive_ack(i);
      end
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (m_acc[0]) break;
      end
      check("send_accepted", m_acc[0], 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic settled;
      settled = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (m_phase[0] == 0 && m_phase[1] == 0 && !rx_ack[0] && !rx_ack[1] &&
             m_hist[0] == 4'd0 && m_hist[1] == 4'd0) begin
            settled = 1'b1;
            break;
         end
         tick();
      end
      check("idle_reached", settled, 1'b1);
   endtask

   initial begin
      int base, nacc, ndone, d0;
      sync_n[0] = S0; sync_n[1] = S1;
      tmo[0] = TO0;   tmo[1] = TO1;
      for (int i = 0; i < 2; i++) begin
         model_reset(i);
         rx_ack[i] = 1'b0; mode[i] = 0; dcnt[i] = 0; rise_edge[i] = -1;
         last_ack[i] = 1'b0; prev_req[i] = 1'b0; n_done_dut[i] = 0;
      end
      rst = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Single transfer, destination acks 3 cycles after seeing the request.
      dmin = 3; dmax = 3; dcnt[0] = 3; dcnt[1] = 3;
      d0 = n_done_dut[0];
      send(8'hA5);
      check("t1_req", tx_req[0], 1'b1);
      check("t1_data", tx_data[0], 8'hA5);
      wait_idle();
      check("t1_cnt", xfer_cnt[0], 16'd1);
      check("t1_done_pulses", n_done_dut[0] - d0, 1);
      dmin = 0; dmax = 4;

      // Back-to-back words with in_valid held.
      base = m_cnt[0]; nacc = 0; ndone = 0;
      in_valid = 1'b1; in_data = 8'h01;
      for (int k = 0; k < 300 && ndone < 3; k++) begin
         tick();
         if (m_done[0]) ndone++;
         if (m_acc[0]) begin
            nacc++;
            check("t2_data", tx_data[0], nacc);
            if (nacc == 3) in_valid = 1'b0;
            else in_data = 8'(nacc + 1);
         end
      end
      in_valid = 1'b0;
      check("t2_done_count", ndone, 3);
      check("t2_cnt", xfer_cnt[0], 16'(base + 3));
      wait_idle();

      // Timeout with no ack, clear while still stuck, then late completion.
      mode[0] = 1; rx_ack[0] = 1'b0;
      send(8'h3C);
      repeat (15) tick();
      check("t3_err_early", err[0], 1'b0);
      tick();
      check("t3_err_set", err[0], 1'b1);
      check("t3_req_held", tx_req[0], 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t3_err_clr", err[0], 1'b0);
      tick();
      check("t3_err_reset", err[0], 1'b1);
      mode[0] = 0; dcnt[0] = 0;
      wait_idle();
      check("t3_err_sticky", err[0], 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t3_err_cleared", err[0], 1'b0);

      // Asynchronous reset mid-request with the ack held high.
      mode[0] = 1; rx_ack[0] = 1'b0;
      send(8'hC3);
      rx_ack[0] = 1'b1;
      tick();
      tick();
      check("t4_pre_req", tx_req[0], 1'b1);
      rst = 1'b1;
      model_reset(0); model_reset(1);
      #1;
      check("t4_req_rst", tx_req[0], 1'b0);
      check("t4_data_rst", tx_data[0], 8'h00);
      check("t4_cnt_rst", xfer_cnt[0], 16'h0000);
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("t4_stale_ack", in_ready[0], 1'b0);
      rx_ack[0] = 1'b0;
      tick();
      check("t4_ready_wait", in_ready[0], 1'b0);
      tick();
      check("t4_ready_back", in_ready[0], 1'b1);
      mode[0] = 0; dcnt[0] = 0;
      wait_idle();

      // Transfer count wrap.
      force dut0.xfer_cnt_q = 16'hFFFF;
      force dut1.xfer_cnt_q = 16'hFFFF;
      m_cnt[0] = 16'hFFFF; m_cnt[1] = 16'hFFFF;
      tick();
      tick();
      release dut0.xfer_cnt_q;
      release dut1.xfer_cnt_q;
      tick();
      d0 = n_done_dut[0];
      send(8'h5A);
      wait_idle();
      check("t5_wrap", xfer_cnt[0], 16'h0000);
      check("t5_done_pulses", n_done_dut[0] - d0, 1);

      // Randomized traffic with random ack delays and occasional err_clr.
      for (int k = 0; k < 1500; k++) begin
         in_valid = ($urandom_range(3, 0) != 0);
         in_data  = 8'($urandom);
         err_clr  = ($urandom_range(31, 0) == 0);
         tick();
      end
      in_valid = 1'b0;
      err_clr  = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
